prbs_checker: RTL and testbench

Serial PRBS checker that sits directly downstream of the `lfsr` generator and consumes its output stream. It takes one bit per valid cycle (normally `lfsr_out[0]`, the newest generated bit) and self-synchronises a local copy of the generator register. Once locked, it predicts every following bit, flags and counts mismatches, and drops lock when the error density is too high. It is used for link and loopback BER checks of the pseudo-random source.

---
 rtl/lfsr_pkg.sv | 14 +
 rtl/sat_counter.sv | 27 ++
 rtl/prbs_checker.sv | 165 ++++++++++++++++
 tb/tb_prbs_checker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the PRBS generator/checker pair.
// The sync state encoding is visible on the checker's sync_state port.
package lfsr_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam logic [31:0] DEFAULT_TAPS  = 32'h80200003;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear that coincides with an increment leaves the count at one, so no event is lost.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= CNT_W'(i_inc);
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: fills and verifies a local copy of the generator
// register, then free-runs it to count bit errors and drops lock on excessive error density.
module prbs_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned       WIDTH      = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  TAPS       = WIDTH'(DEFAULT_TAPS),
  parameter int unsigned       VERIFY_LEN = 64,
  parameter int unsigned       WINDOW_LEN = 1024,
  parameter int unsigned       ERR_THRESH = 16,
  parameter int unsigned       CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clr_cnt,
  output logic             locked,
  output logic [1:0]       sync_state,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned FILL_W = $clog2(WIDTH + 1);
  localparam int unsigned VER_W  = $clog2(VERIFY_LEN + 1);
  localparam int unsigned WIN_W  = $clog2(WINDOW_LEN + 1);
  localparam int unsigned ERR_W  = $clog2(ERR_THRESH + 1);

  sync_state_t        r_state,     w_state_d;
  logic [WIDTH-1:0]   r_shreg,     w_shreg_d;
  logic [FILL_W-1:0]  r_fill_cnt,  w_fill_cnt_d;
  logic [VER_W-1:0]   r_ver_cnt,   w_ver_cnt_d;
  logic [WIN_W-1:0]   r_win_cnt,   w_win_cnt_d;
  logic [ERR_W-1:0]   r_win_err,   w_win_err_d;
  logic               r_err_pulse, w_err_pulse_d;

  logic               w_pred;
  logic               w_mismatch;
  logic [WIDTH-1:0]   w_shreg_rx;
  logic [WIN_W-1:0]   w_win_cnt_inc;
  logic [ERR_W-1:0]   w_win_err_inc;
  logic               w_bit_inc;
  logic               w_err_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FILL;
      r_shreg     <= '0;
      r_fill_cnt  <= '0;
      r_ver_cnt   <= '0;
      r_win_cnt   <= '0;
      r_win_err   <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_shreg     <= w_shreg_d;
      r_fill_cnt  <= w_fill_cnt_d;
      r_ver_cnt   <= w_ver_cnt_d;
      r_win_cnt   <= w_win_cnt_d;
      r_win_err   <= w_win_err_d;
      r_err_pulse <= w_err_pulse_d;
    end
  end

  always_comb begin
    w_pred        = ^(r_shreg & TAPS);
    w_mismatch    = bit_in ^ w_pred;
    w_shreg_rx    = {r_shreg[WIDTH-2:0], bit_in};
    w_win_cnt_inc = r_win_cnt + WIN_W'(1);
    w_win_err_inc = r_win_err + ERR_W'(w_mismatch);

    w_state_d     = r_state;
    w_shreg_d     = r_shreg;
    w_fill_cnt_d  = r_fill_cnt;
    w_ver_cnt_d   = r_ver_cnt;
    w_win_cnt_d   = r_win_cnt;
    w_win_err_d   = r_win_err;
    w_err_pulse_d = 1'b0;
    w_bit_inc     = 1'b0;
    w_err_inc     = 1'b0;

    if (bit_valid) begin
      unique case (r_state)
        FILL: begin
          w_shreg_d = w_shreg_rx;
          if (r_fill_cnt == FILL_W'(WIDTH - 1)) begin
            w_fill_cnt_d = '0;
            // An all-zero register is the LFSR lock-up state; keep filling.
            if (w_shreg_rx != '0) begin
              w_state_d   = VERIFY;
              w_ver_cnt_d = '0;
            end
          end else begin
            w_fill_cnt_d = r_fill_cnt + FILL_W'(1);
          end
        end

        VERIFY: begin
          w_shreg_d = w_shreg_rx;
          if (w_mismatch) begin
            w_ver_cnt_d = '0;
          end else if (r_ver_cnt == VER_W'(VERIFY_LEN - 1)) begin
            w_state_d   = LOCKED;
            w_ver_cnt_d = '0;
            w_win_cnt_d = '0;
            w_win_err_d = '0;
          end else begin
            w_ver_cnt_d = r_ver_cnt + VER_W'(1);
          end
        end

        LOCKED: begin
          // Free-run on the prediction so a flipped input bit costs exactly one error.
          w_shreg_d     = {r_shreg[WIDTH-2:0], w_pred};
          w_bit_inc     = 1'b1;
          w_err_inc     = w_mismatch;
          w_err_pulse_d = w_mismatch;
          if (w_mismatch && (w_win_err_inc == ERR_W'(ERR_THRESH))) begin
            w_state_d    = FILL;
            w_fill_cnt_d = '0;
            w_win_cnt_d  = '0;
            w_win_err_d  = '0;
          end else if (w_win_cnt_inc == WIN_W'(WINDOW_LEN)) begin
            w_win_cnt_d = '0;
            w_win_err_d = '0;
          end else begin
            w_win_cnt_d = w_win_cnt_inc;
            w_win_err_d = w_win_err_inc;
          end
        end

        default: begin
          w_state_d    = FILL;
          w_fill_cnt_d = '0;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_err_inc),
    .i_clr   (clr_cnt),
    .o_count (err_count)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_bit_inc),
    .i_clr   (clr_cnt),
    .o_count (bit_count)
  );

  assign locked     = (r_state == LOCKED);
  assign sync_state = r_state;
  assign err_pulse  = r_err_pulse;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a reference LFSR feeds the checker and a queue holds the
// expected err_pulse for every driven bit, popped after the accepting edge.
module tb_prbs_checker;
  import lfsr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_valid;
  logic        bit_in;
  logic        clr_cnt;
  logic        locked;
  logic [1:0]  sync_state;
  logic        err_pulse;
  logic [31:0] err_count;
  logic [31:0] bit_count;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] gen;
  logic        exp_locked;
  int unsigned win_pos;
  logic [31:0] exp_errs;
  logic [31:0] exp_bits;
  logic        exp_q[$];

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk        (clk),
    .rst        (rst),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .clr_cnt    (clr_cnt),
    .locked     (locked),
    .sync_state (sync_state),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .bit_count  (bit_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic gen_bit(output logic b);
    logic fb;
    fb  = ^(gen & DEFAULT_TAPS);
    gen = {gen[30:0], fb};
    b   = fb;
  endtask

  // Drive one cycle, update the expected counters, then check err_pulse from the scoreboard.
  task automatic step(input logic v, input logic b, input logic flip, input logic clr);
    logic exp_p;
    logic counted;
    @(negedge clk);
    bit_valid = v;
    bit_in    = b;
    clr_cnt   = clr;
    counted   = v && exp_locked;
    exp_p     = counted && flip;
    exp_q.push_back(exp_p);
    if (clr) begin
      exp_bits = counted ? 32'd1 : 32'd0;
      exp_errs = exp_p ? 32'd1 : 32'd0;
    end else if (counted) begin
      exp_bits = exp_bits + 32'd1;
      if (exp_p) exp_errs = exp_errs + 32'd1;
    end
    if (counted) win_pos = (win_pos + 1) % 1024;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    clr_cnt   = 1'b0;
    chk("err_pulse", {31'b0, err_pulse}, {31'b0, exp_q.pop_front()});
  endtask

  task automatic send(input logic v, input logic flip, input logic clr);
    logic b;
    b = 1'b0;
    if (v) begin
      gen_bit(b);
      b = b ^ flip;
    end
    step(v, b, flip, clr);
  endtask

  task automatic lock_up();
    repeat (31) send(1'b1, 1'b0, 1'b0);
    chk("fill_state", {30'b0, sync_state}, 32'd0);
    send(1'b1, 1'b0, 1'b0);
    chk("verify_state", {30'b0, sync_state}, 32'd1);
    repeat (63) send(1'b1, 1'b0, 1'b0);
    chk("not_yet_locked", {31'b0, locked}, 32'd0);
    send(1'b1, 1'b0, 1'b0);
    chk("locked_at_96", {31'b0, locked}, 32'd1);
    chk("locked_state", {30'b0, sync_state}, 32'd2);
    exp_locked = 1'b1;
    win_pos    = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {err_count[15:0], bit_count[12:0], locked, sync_state},
        {16'b0, 13'b0, 1'b0, 2'b0});
    chk({tag, "_pulse"}, {31'b0, err_pulse}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    bit_valid  = 1'b0;
    bit_in     = 1'b0;
    clr_cnt    = 1'b0;
    gen        = 32'h1;
    exp_locked = 1'b0;
    win_pos    = 0;
    exp_errs   = '0;
    exp_bits   = '0;

    #12;
    chk_all_zero("reset");
    chk("reset_err_count", err_count, 32'd0);
    chk("reset_bit_count", bit_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Clean lock and 1000 checked bits
    lock_up();
    repeat (1000) send(1'b1, 1'b0, 1'b0);
    chk("clean_bit_count", bit_count, 32'd1000);
    chk("clean_err_count", err_count, 32'd0);

    // Single flipped bit
    send(1'b1, 1'b1, 1'b0);
    chk("single_err_count", err_count, 32'd1);
    chk("single_locked", {31'b0, locked}, 32'd1);
    repeat (100) send(1'b1, 1'b0, 1'b0);
    chk("single_err_hold", err_count, 32'd1);
    chk("single_bit_count", bit_count, exp_bits);

    // clr_cnt with a clean bit
    send(1'b1, 1'b0, 1'b1);
    chk("clr_bit_count", bit_count, 32'd1);
    chk("clr_err_count", err_count, 32'd0);

    // 15 errors at the tail of each of 4 windows
    while (win_pos != 0) send(1'b1, 1'b0, 1'b0);
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 1024; i++) send(1'b1, (i >= 1009), 1'b0);
      chk("window_locked", {31'b0, locked}, 32'd1);
    end
    chk("window_err_count", err_count, 32'd60);
    chk("window_bit_count", bit_count, exp_bits);

    // clr_cnt colliding with an error
    send(1'b1, 1'b1, 1'b1);
    chk("clr_err_collide", err_count, 32'd1);
    chk("clr_bit_collide", bit_count, 32'd1);

    // 16 errors in one window: loss of lock and relock
    while (win_pos != 0) send(1'b1, 1'b0, 1'b0);
    repeat (15) send(1'b1, 1'b1, 1'b0);
    chk("pre_loss_locked", {31'b0, locked}, 32'd1);
    send(1'b1, 1'b1, 1'b0);
    exp_locked = 1'b0;
    chk("loss_state", {30'b0, sync_state}, 32'd0);
    chk("loss_err_count", err_count, 32'd17);
    lock_up();
    chk("relock_err_hold", err_count, 32'd17);
    chk("relock_bit_hold", bit_count, exp_bits);

    // Asynchronous reset while locked
    repeat (5) send(1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst        = 1'b0;
    exp_locked = 1'b0;
    exp_errs   = '0;
    exp_bits   = '0;

    // 50% valid: lock latency doubles in cycles
    for (int i = 0; i < 191; i++) send((i % 2 == 1), 1'b0, 1'b0);
    chk("gap_not_locked", {31'b0, locked}, 32'd0);
    send(1'b1, 1'b0, 1'b0);
    chk("gap_locked_192", {31'b0, locked}, 32'd1);
    exp_locked = 1'b1;
    win_pos    = 0;
    for (int i = 0; i < 200; i++) send((i % 2 == 1), 1'b0, 1'b0);
    chk("gap_bit_count", bit_count, 32'd100);
    chk("gap_err_count", err_count, 32'd0);

    // All-zero input never leaves FILL
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    exp_locked = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("zero_fill", {29'b0, locked, sync_state}, 32'd0);
    end
    chk("zero_bit_count", bit_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
